// File: rtl/mil_word_encoder_pkg.sv
// Shared MIL-STD-1553 encoder definitions: word framing lengths, encoder
// state type and small helpers for parity and sync levels.
package milStd1553;

  localparam int MIL_WORD_BITS       = 16;
  localparam int MIL_SYNC_HALFBITS   = 6;
  localparam int MIL_DATA_HALFBITS   = 32;
  localparam int MIL_PARITY_HALFBITS = 2;

  typedef enum logic [2:0] {
    ENC_IDLE,
    ENC_GAP,
    ENC_SYNC,
    ENC_BITS,
    ENC_PARITY
  } MilEncState_t;

  // Odd parity over the 16 data bits: set when the word has an even number of ones.
  function automatic logic mil_odd_parity(input logic [MIL_WORD_BITS-1:0] word);
    return ~^word;
  endfunction

  // Sync pattern: command words are high for the first three half-bits then low,
  // data words are the mirror image.
  function automatic logic mil_sync_level(input logic is_cmd, input logic [5:0] idx);
    return is_cmd ^ (idx >= 6'd3);
  endfunction

endpackage

// File: rtl/mil_word_encoder_if.sv
// Word handshake between the ring-buffer read side (master) and the
// Manchester encoder (slave). The optional inject_parity_err signal exists only
// when MIL_ENC_PARITY_INJECT_EN is defined.
interface mil_word_encoder_if;
  import milStd1553::*;

  logic [MIL_WORD_BITS-1:0] in_data;
  logic                     in_type;
  logic                     in_valid;
  logic                     in_ready;
`ifdef MIL_ENC_PARITY_INJECT_EN
  logic                     inject_parity_err;
`endif

  modport master (
`ifdef MIL_ENC_PARITY_INJECT_EN
    output inject_parity_err,
`endif
    output in_data,
    output in_type,
    output in_valid,
    input  in_ready
  );

  modport slave (
`ifdef MIL_ENC_PARITY_INJECT_EN
    input  inject_parity_err,
`endif
    input  in_data,
    input  in_type,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/mil_word_encoder_halfbit_timer.sv
// Half-bit timer: counts clk cycles and pulses tick on the last cycle of every
// half-bit. restart zeroes the count so a new half-bit starts on the next cycle.
module mil_halfbit_timer #(
  parameter int HALF_BIT_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == LAST);

  // Next count: wrap at the end of a half-bit or when a new phase restarts timing.
  always_comb begin
    count_d = count_q + 1'b1;
    if (restart || tick) begin
      count_d = '0;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mil_word_encoder.sv
// MIL-STD-1553 Manchester-II word encoder. Accepts 16-bit words through a
// one-entry holding register and drives the TX line pair with a 3 us sync,
// 16 data bits (MSB first) and odd parity. Data words chain gap-free; a command
// word following another word is preceded by GAP_HALFBITS idle half-bits.
// Optional feature macro: MIL_ENC_PARITY_INJECT_EN (inverts the parity bit of
// words accepted with inject_parity_err set).
module mil_word_encoder
  import milStd1553::*;
#(
  parameter int HALF_BIT_CYCLES = 50,
  parameter int GAP_HALFBITS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  mil_word_encoder_if.slave in_if,
  output logic              tx_out,
  output logic              ntx_out,
  output logic              busy,
  output logic              word_done
);

  localparam logic [5:0] SYNC_LAST   = 6'(MIL_SYNC_HALFBITS - 1);
  localparam logic [5:0] DATA_LAST   = 6'(MIL_DATA_HALFBITS - 1);
  localparam logic [5:0] PARITY_LAST = 6'(MIL_PARITY_HALFBITS - 1);
  localparam logic [5:0] GAP_LAST    = 6'(GAP_HALFBITS - 1);

  MilEncState_t             state_q, state_d;
  logic [5:0]               idx_q, idx_d;
  logic [MIL_WORD_BITS-1:0] shift_q, shift_d;
  logic                     cur_type_q, cur_type_d;
  logic                     parity_q, parity_d;
  logic                     prev_word_q, prev_word_d;
  logic                     done_pend_q, done_pend_d;
  logic                     word_done_q, word_done_d;
  logic                     tx_q, tx_d;
  logic                     ntx_q, ntx_d;

  logic                     hold_full_q, hold_full_d;
  logic [MIL_WORD_BITS-1:0] hold_data_q, hold_data_d;
  logic                     hold_type_q, hold_type_d;
  logic                     hold_inj_q, hold_inj_d;

  logic                     halfbit_tick;
  logic                     do_load;
  logic                     do_gap;
  logic                     accept;
  logic                     in_inj;
  logic                     line_level;

`ifdef MIL_ENC_PARITY_INJECT_EN
  assign in_inj = in_if.inject_parity_err;
`else
  assign in_inj = 1'b0;
`endif

  assign accept       = in_if.in_valid & ~hold_full_q;
  assign in_if.in_ready = ~hold_full_q;
  assign busy         = (state_q != ENC_IDLE) | hold_full_q;
  assign tx_out       = tx_q;
  assign ntx_out      = ntx_q;
  assign word_done    = word_done_q;

  mil_halfbit_timer #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(do_load | do_gap),
    .tick   (halfbit_tick)
  );

  // Holding register: captures a word on the accepting edge, empties when the FSM loads it.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_type_d = hold_type_q;
    hold_inj_d  = hold_inj_q;
    if (do_load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = in_if.in_data;
      hold_type_d = in_if.in_type;
      hold_inj_d  = in_inj;
    end
  end

  // Framing FSM: walks sync, data and parity half-bits and decides chain, gap or idle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    cur_type_d  = cur_type_q;
    parity_d    = parity_q;
    prev_word_d = prev_word_q;
    done_pend_d = 1'b0;
    do_load     = 1'b0;
    do_gap      = 1'b0;

    case (state_q)
      ENC_IDLE: begin
        prev_word_d = 1'b0;
        if (hold_full_q) begin
          if (hold_type_q && prev_word_q) begin
            do_gap = 1'b1;
          end else begin
            do_load = 1'b1;
          end
        end
      end
      ENC_GAP: begin
        if (halfbit_tick) begin
          if (idx_q == GAP_LAST) begin
            do_load = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ENC_SYNC: begin
        if (halfbit_tick) begin
          if (idx_q == SYNC_LAST) begin
            state_d = ENC_BITS;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ENC_BITS: begin
        if (halfbit_tick) begin
          if (idx_q[0]) begin
            shift_d = {shift_q[MIL_WORD_BITS-2:0], 1'b0};
          end
          if (idx_q == DATA_LAST) begin
            state_d = ENC_PARITY;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ENC_PARITY: begin
        if (halfbit_tick) begin
          if (idx_q == PARITY_LAST) begin
            done_pend_d = 1'b1;
            prev_word_d = 1'b1;
            if (hold_full_q) begin
              if (hold_type_q) begin
                do_gap = 1'b1;
              end else begin
                do_load = 1'b1;
              end
            end else begin
              state_d     = ENC_IDLE;
              idx_d       = 6'd0;
              prev_word_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = ENC_IDLE;
        idx_d   = 6'd0;
      end
    endcase

    if (do_gap) begin
      state_d = ENC_GAP;
      idx_d   = 6'd0;
    end
    if (do_load) begin
      state_d    = ENC_SYNC;
      idx_d      = 6'd0;
      shift_d    = hold_data_q;
      cur_type_d = hold_type_q;
      parity_d   = mil_odd_parity(hold_data_q) ^ hold_inj_q;
    end
  end

  // Line levels for the current half-bit; registered so the lines lag the FSM by one cycle.
  always_comb begin
    line_level  = 1'b0;
    tx_d        = 1'b0;
    ntx_d       = 1'b0;
    word_done_d = done_pend_q;
    case (state_q)
      ENC_SYNC: begin
        line_level = mil_sync_level(cur_type_q, idx_q);
        tx_d       = line_level;
        ntx_d      = ~line_level;
      end
      ENC_BITS: begin
        line_level = shift_q[MIL_WORD_BITS-1] ^ idx_q[0];
        tx_d       = line_level;
        ntx_d      = ~line_level;
      end
      ENC_PARITY: begin
        line_level = parity_q ^ idx_q[0];
        tx_d       = line_level;
        ntx_d      = ~line_level;
      end
      default: begin
        tx_d  = 1'b0;
        ntx_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any word in flight or held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ENC_IDLE;
      idx_q       <= 6'd0;
      shift_q     <= '0;
      cur_type_q  <= 1'b0;
      parity_q    <= 1'b0;
      prev_word_q <= 1'b0;
      done_pend_q <= 1'b0;
      word_done_q <= 1'b0;
      tx_q        <= 1'b0;
      ntx_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_type_q <= 1'b0;
      hold_inj_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      cur_type_q  <= cur_type_d;
      parity_q    <= parity_d;
      prev_word_q <= prev_word_d;
      done_pend_q <= done_pend_d;
      word_done_q <= word_done_d;
      tx_q        <= tx_d;
      ntx_q       <= ntx_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_type_q <= hold_type_d;
      hold_inj_q  <= hold_inj_d;
    end
  end

endmodule

// File: tb/tb_mil_word_encoder.sv
// Self-checking bench for mil_word_encoder. A schedule of accepted words, each
// with its computed line start cycle, predicts tx/ntx/word_done for every clock
// cycle from the Manchester framing rules; a monitor compares every cycle.
module tb_mil_word_encoder;

  localparam int HB       = 50;
  localparam int GAP      = 8;
  localparam int WORD_CYC = 40 * HB;

  typedef struct {
    int          start;
    logic        isCmd;
    logic [15:0] data;
    logic        inj;
  } SchedEntry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_out, ntx_out, busy, word_done;

  int vectorCount = 0;
  int missCount   = 0;
  int cyc         = 0;
  int lastEnd     = -100000;
  bit monitorOn   = 1'b0;
  SchedEntry_t sched[$];

  mil_word_encoder_if ifc();

  mil_word_encoder #(
    .HALF_BIT_CYCLES(HB),
    .GAP_HALFBITS   (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_if    (ifc),
    .tx_out   (tx_out),
    .ntx_out  (ntx_out),
    .busy     (busy),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  // Cycle index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
      if (missCount >= 50) begin
        $display("[TB] FAIL too many miscompares, stopping");
        $fatal(1);
      end
    end
  endtask

  // Level of half-bit h (0..39) of a word: 6 sync, 32 data, 2 parity.
  function automatic logic halfBitLevel(input logic isCmd, input logic [15:0] data, input logic inj, input int h);
    logic bitv;
    logic p;
    if (h < 6) return isCmd ? (h < 3) : (h >= 3);
    if (h < 38) begin
      bitv = data[15 - (h - 6) / 2];
      return ((h - 6) % 2 == 0) ? bitv : ~bitv;
    end
    p = (~^data) ^ inj;
    return (h == 38) ? p : ~p;
  endfunction

  // Expected {tx, ntx, word_done} after edge c.
  function automatic logic [2:0] expectedLines(input int c);
    logic [2:0] r;
    logic v;
    r = 3'b000;
    foreach (sched[i]) begin
      if (c >= sched[i].start && c < sched[i].start + WORD_CYC) begin
        v = halfBitLevel(sched[i].isCmd, sched[i].data, sched[i].inj, (c - sched[i].start) / HB);
        r[2] = v;
        r[1] = ~v;
      end
      if (c == sched[i].start + WORD_CYC) r[0] = 1'b1;
    end
    return r;
  endfunction

  // Every cycle away from the edge, compare the line pair and done pulse against the schedule.
  always @(negedge clk) begin
    if (monitorOn) checkOutput("lines", {tx_out, ntx_out, word_done}, expectedLines(cyc));
  end

  // Offer one word, wait (bounded) for acceptance and schedule its transmission.
  task automatic applyStimulus(input logic isCmd, input logic [15:0] data, input logic inj);
    int waitCyc = 0;
    int a;
    int st;
    SchedEntry_t e;
    @(negedge clk);
    ifc.in_data  = data;
    ifc.in_type  = isCmd;
`ifdef MIL_ENC_PARITY_INJECT_EN
    ifc.inject_parity_err = inj;
`endif
    ifc.in_valid = 1'b1;
    while (!ifc.in_ready && waitCyc < 5000) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!ifc.in_ready) begin
      checkOutput("acceptTimeout", ifc.in_ready, 1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    a = cyc;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 16'($urandom);
    ifc.in_type  = 1'($urandom_range(0, 1));
    st = (a <= lastEnd - 2) ? lastEnd + (isCmd ? GAP * HB : 0) : a + 2;
    e.start = st;
    e.isCmd = isCmd;
    e.data  = data;
`ifdef MIL_ENC_PARITY_INJECT_EN
    e.inj   = inj;
`else
    e.inj   = 1'b0;
`endif
    sched.push_back(e);
    lastEnd = st + WORD_CYC;
  endtask

  // Hold reset for n edges, checking idle outputs, then release and recheck.
  task automatic resetDut(input int n);
    @(negedge clk);
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    @(posedge clk);
    sched.delete();
    lastEnd = -100000;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("rstTx", tx_out, 0);
      checkOutput("rstNtx", ntx_out, 0);
      checkOutput("rstReady", ifc.in_ready, 1);
      checkOutput("rstBusy", busy, 0);
      if (i < n - 1) @(posedge clk);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("relReady", ifc.in_ready, 1);
      checkOutput("relBusy", busy, 0);
    end
  endtask

  // Let every scheduled word finish, then confirm the encoder went idle.
  task automatic waitDrain();
    int n;
    n = lastEnd - cyc + 5;
    if (n < 1) n = 1;
    repeat (n) @(negedge clk);
    checkOutput("drainBusy", busy, 0);
    checkOutput("drainReady", ifc.in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int mode;
    int tgt;
    int st;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 16'h0000;
    ifc.in_type  = 1'b0;
`ifdef MIL_ENC_PARITY_INJECT_EN
    ifc.inject_parity_err = 1'b0;
`endif
    @(posedge clk);
    #1;
    monitorOn = 1'b1;

    $display("[TB] reset");
    resetDut(5);

    $display("[TB] single command word");
    applyStimulus(1'b1, 16'h0001, 1'b0);
    waitDrain();

    $display("[TB] command followed by chained data words");
    applyStimulus(1'b1, 16'h0001, 1'b0);
    applyStimulus(1'b0, 16'h0002, 1'b0);
    applyStimulus(1'b0, 16'hAB45, 1'b0);
    applyStimulus(1'b0, 16'hFFA1, 1'b0);
    waitDrain();

    $display("[TB] data word then held command (gap)");
    applyStimulus(1'b0, 16'h1234, 1'b0);
    applyStimulus(1'b1, 16'h0421, 1'b0);
    waitDrain();

    $display("[TB] reset mid-word");
    applyStimulus(1'b0, 16'hAB45, 1'b0);
    st = sched[$].start;
    applyStimulus(1'b0, 16'h5A5A, 1'b0);
    while (cyc < st + 20 * HB + 10) @(negedge clk);
    resetDut(2);
    applyStimulus(1'b0, 16'h0002, 1'b0);
    waitDrain();

`ifdef MIL_ENC_PARITY_INJECT_EN
    $display("[TB] parity injection");
    applyStimulus(1'b1, 16'h0001, 1'b1);
    waitDrain();
`endif

    $display("[TB] randomized words");
    for (int i = 0; i < 12; i++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        repeat ($urandom_range(0, 1200)) @(negedge clk);
      end else if (mode == 1) begin
        tgt = lastEnd - int'($urandom_range(0, 3)) - 2;
        while (cyc < tgt) @(negedge clk);
      end
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
